// File: rtl/y_issue_pkg.sv
// Shared types and constants for the y_alu issue/writeback stage.
// The opcode values mirror the encoding understood by yAlu.
package y_issue_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/y_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Entry 0 always reads as zero and is never written.
module y_regfile #(
  parameter int NREGS = y_issue_pkg::NREGS,
  parameter int WIDTH = y_issue_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [WIDTH-1:0]         ra_data,
  output logic [WIDTH-1:0]         rb_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa_addr,
  input  logic [WIDTH-1:0]         wa_data
);
  import y_issue_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] mem_r [NREGS];

  // Storage: cleared on reset, written when enabled to a nonzero address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we && (wa_addr != {AW{1'b0}})) begin
      mem_r[wa_addr] <= wa_data;
    end
  end

  // Read ports: address zero is forced to zero.
  always_comb begin
    ra_data = {WIDTH{1'b0}};
    rb_data = {WIDTH{1'b0}};
    if (ra_addr != {AW{1'b0}}) begin
      ra_data = mem_r[ra_addr];
    end else begin
      ra_data = {WIDTH{1'b0}};
    end
    if (rb_addr != {AW{1'b0}}) begin
      rb_data = mem_r[rb_addr];
    end else begin
      rb_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/y_alu_issue.sv
// Issue/writeback stage around an external combinational yAlu: reads operands,
// registers them toward the ALU, captures the result, writes it back and presents it.
module y_alu_issue #(
  parameter int NREGS = y_issue_pkg::NREGS,
  parameter int WIDTH = y_issue_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREGS)-1:0] in_rs,
  input  logic [$clog2(NREGS)-1:0] in_rt,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [2:0]               in_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_z,
  input  logic                     alu_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic [WIDTH-1:0]         out_z,
  output logic                     out_zero
);
  import y_issue_pkg::*;

  localparam int AW = $clog2(NREGS);

  state_e           state_r;
  logic [AW-1:0]    rd_r;
  logic [WIDTH-1:0] rs_data_s;
  logic [WIDTH-1:0] rt_data_s;
  logic             accept_s;
  logic             wb_en_s;

  assign accept_s = in_valid & in_ready;
  assign wb_en_s  = (state_r == EXEC);

  // Writeback lands on the EXEC edge, so a following accept already reads the new value.
  y_regfile #(
    .NREGS (NREGS),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (in_rs),
    .rb_addr (in_rt),
    .ra_data (rs_data_s),
    .rb_data (rt_data_s),
    .we      (wb_en_s),
    .wa_addr (rd_r),
    .wa_data (alu_z)
  );

  // Handshake strobes decoded from state; held low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready  = 1'b1;
          out_valid = 1'b0;
        end
        RESP: begin
          in_ready  = out_ready;
          out_valid = 1'b1;
        end
        default: begin
          in_ready  = 1'b0;
          out_valid = 1'b0;
        end
      endcase
    end
  end

  // Sequencer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      alu_a    <= {WIDTH{1'b0}};
      alu_b    <= {WIDTH{1'b0}};
      alu_op   <= 3'b000;
      rd_r     <= {AW{1'b0}};
      out_rd   <= {AW{1'b0}};
      out_z    <= {WIDTH{1'b0}};
      out_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a   <= rs_data_s;
            alu_b   <= rt_data_s;
            alu_op  <= in_op;
            rd_r    <= in_rd;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          out_z    <= alu_z;
          out_zero <= alu_zero;
          out_rd   <= rd_r;
          state_r  <= RESP;
        end
        RESP: begin
          if (accept_s) begin
            alu_a   <= rs_data_s;
            alu_b   <= rt_data_s;
            alu_op  <= in_op;
            rd_r    <= in_rd;
            state_r <= EXEC;
          end else if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_alu_issue.sv
// Bench for y_alu_issue: behavioural yAlu stand-in, directed vector table,
// stall/reset sequences and a randomized run against a register-file model.
module tb_y_alu_issue;
  import y_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [2:0]  in_op;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_z;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_z;
  logic        out_zero;

  logic        imm_en;
  logic [31:0] imm_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y_alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_z(out_z), .out_zero(out_zero)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op[1:0])
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return op[2] ? (a - b) : (a + b);
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Stand-in for yAlu; imm_en lets the bench inject a constant result.
  always_comb begin
    alu_z    = imm_en ? imm_val : alu_f(alu_a, alu_b, alu_op);
    alu_zero = (alu_z == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // One instruction with out_ready held high; checks latency and result.
  task automatic do_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [2:0] op, input logic ie, input logic [31:0] iv,
                       input logic [31:0] ez, input logic ezero, input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_op = op;
    imm_en = ie; imm_val = iv; out_ready = 1'b1;
    #1;
    for (n = 0; n < 20 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    if (n >= 20) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_exec_valid"}, out_valid, 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 32'd1);
    chk({nm, "_z"}, out_z, ez);
    chk({nm, "_zero"}, out_zero, ezero);
    chk({nm, "_rd"}, out_rd, rd);
    @(posedge clk); #1;
    imm_en = 1'b0;
  endtask

  // Random-phase reference model: architectural registers plus the one result in flight.
  logic [31:0] rf_m [32];
  bit          m_busy;
  int          m_age;
  logic [31:0] m_a, m_b, m_z;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;

  task automatic rnd_cycle(input bit allow_in, output bit acc);
    bit exp_ov, exp_ir, pop;
    @(negedge clk);
    in_valid  = allow_in && ($urandom_range(0, 3) != 0);
    in_rs     = 5'($urandom);
    in_rt     = 5'($urandom);
    in_rd     = 5'($urandom);
    in_op     = 3'($urandom);
    out_ready = allow_in ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    exp_ov = m_busy && (m_age >= 1);
    exp_ir = !m_busy || (exp_ov && out_ready);
    chk("rnd_in_ready", in_ready, exp_ir);
    chk("rnd_out_valid", out_valid, exp_ov);
    if (m_busy && m_age == 0) begin
      chk("rnd_alu_a", alu_a, m_a);
      chk("rnd_alu_b", alu_b, m_b);
      chk("rnd_alu_op", alu_op, m_op);
    end
    if (exp_ov) begin
      chk("rnd_out_z", out_z, m_z);
      chk("rnd_out_zero", out_zero, (m_z == 32'd0));
      chk("rnd_out_rd", out_rd, m_rd);
    end
    pop = exp_ov && out_ready;
    acc = in_valid && exp_ir;
    if (pop) m_busy = 1'b0;
    if (acc) begin
      m_a  = rf_m[in_rs];
      m_b  = rf_m[in_rt];
      m_op = in_op;
      m_rd = in_rd;
      m_z  = alu_f(m_a, m_b, m_op);
      if (in_rd != 5'd0) rf_m[in_rd] = m_z;
      m_busy = 1'b1;
    end
    @(posedge clk);
    if (acc) m_age = 0;
    else m_age++;
  endtask

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [2:0]  op;
    logic        ie;
    logic [31:0] iv;
    logic [31:0] ez;
    logic        ezero;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit          acc;
    int          n_ops, cyc;
    logic [31:0] v;

    vecs[0] = '{5'd0, 5'd0, 5'd1, OP_ADD, 1'b1, 32'd5, 32'd5,  1'b0};
    vecs[1] = '{5'd0, 5'd0, 5'd2, OP_ADD, 1'b1, 32'd7, 32'd7,  1'b0};
    vecs[2] = '{5'd1, 5'd2, 5'd3, OP_ADD, 1'b0, 32'd0, 32'd12, 1'b0};
    vecs[3] = '{5'd1, 5'd1, 5'd4, OP_SUB, 1'b0, 32'd0, 32'd0,  1'b1};
    vecs[4] = '{5'd4, 5'd2, 5'd5, OP_AND, 1'b0, 32'd0, 32'd0,  1'b1};
    vecs[5] = '{5'd2, 5'd2, 5'd0, OP_ADD, 1'b0, 32'd0, 32'd14, 1'b0};
    vecs[6] = '{5'd0, 5'd1, 5'd6, OP_OR,  1'b0, 32'd0, 32'd5,  1'b0};
    vecs[7] = '{5'd1, 5'd2, 5'd7, OP_SLT, 1'b0, 32'd0, 32'd1,  1'b0};

    rst = 1'b1; in_valid = 1'b0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_op = 3'd0; out_ready = 1'b0; imm_en = 1'b0; imm_val = 32'd0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    m_busy = 1'b0; m_age = 0;

    #12;
    chk("rst_in_ready", in_ready, 32'd0);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_out_z", out_z, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].op, vecs[i].ie, vecs[i].iv,
            vecs[i].ez, vecs[i].ezero, $sformatf("vec%0d", i));
    end

    // Back-pressure: ADD r8=r1+r2 held for 10 cycles, SUB r9=r3-r1 waiting behind it.
    @(negedge clk);
    in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd8; in_op = OP_ADD; out_ready = 1'b0;
    @(posedge clk); #1;
    in_rs = 5'd3; in_rt = 5'd1; in_rd = 5'd9; in_op = OP_SUB;
    @(negedge clk);
    chk("stall_exec_in_ready", in_ready, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 32'd1);
      chk("stall_z", out_z, 32'd12);
      chk("stall_rd", out_rd, 32'd8);
      chk("stall_in_ready", in_ready, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_exec_valid", out_valid, 32'd0);
    @(negedge clk);
    chk("release_valid", out_valid, 32'd1);
    chk("release_z", out_z, 32'd7);
    chk("release_rd", out_rd, 32'd9);
    @(posedge clk); #1;

    // Reset during EXEC of ADD r10=r1+r2.
    @(negedge clk);
    in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd10; in_op = OP_ADD; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 32'd0);
    chk("midrst_out_valid", out_valid, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_alu_op", alu_op, 32'd0);
    chk("midrst_out_z", out_z, 32'd0);
    chk("midrst_out_rd", out_rd, 32'd0);
    chk("midrst_out_zero", out_zero, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", in_ready, 32'd1);
    do_op(5'd10, 5'd0, 5'd0, OP_ADD, 1'b0, 32'd0, 32'd0, 1'b1, "postrst_r10");
    do_op(5'd3,  5'd0, 5'd0, OP_ADD, 1'b0, 32'd0, 32'd0, 1'b1, "postrst_r3");

    // Seed every register, then run random traffic.
    for (int i = 1; i < 32; i++) begin
      v = $urandom;
      do_op(5'd0, 5'd0, 5'(i), OP_ADD, 1'b1, v, v, (v == 32'd0), "seed");
      rf_m[i] = v;
    end
    n_ops = 0; cyc = 0;
    while (n_ops < 1000 && cyc < 20000) begin
      rnd_cycle(1'b1, acc);
      if (acc) n_ops++;
      cyc++;
    end
    if (n_ops < 1000) chk("rnd_op_budget", n_ops, 32'd1000);
    for (int i = 0; i < 10 && m_busy; i++) rnd_cycle(1'b0, acc);
    chk("rnd_drain", m_busy, 32'd0);
    in_valid = 1'b0;

    for (int i = 1; i < 32; i++) begin
      do_op(5'(i), 5'd0, 5'd0, OP_ADD, 1'b0, 32'd0, rf_m[i], (rf_m[i] == 32'd0),
            $sformatf("final_r%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
